// File: rtl/cache_mem_responder_if.sv
// Request/return bus between a cache controller (master) and its memory responder (slave).
// Read requests, write requests with a 128-bit line payload, and the beat-wise read return path.
interface cache_mem_responder_if;
   logic         rd_req;
   logic [2:0]   rd_type;
   logic [31:0]  rd_addr;
   logic         rd_rdy;

   logic         ret_valid;
   logic         ret_last;
   logic [31:0]  ret_data;

   logic         wr_req;
   logic [2:0]   wr_type;
   logic [31:0]  wr_addr;
   logic [3:0]   wr_wstrb;
   logic [127:0] wr_data;
   logic         wr_rdy;

   modport master (
      output rd_req, rd_type, rd_addr,
      output wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
      input  rd_rdy, wr_rdy, ret_valid, ret_last, ret_data
   );

   modport slave (
      input  rd_req, rd_type, rd_addr,
      input  wr_req, wr_type, wr_addr, wr_wstrb, wr_data,
      output rd_rdy, wr_rdy, ret_valid, ret_last, ret_data
   );
endinterface

// File: rtl/cache_mem_responder.sv
// Word-organised backing memory that services cache line/word reads with a fixed latency
// and commits line or byte-strobed word writes; writes win over reads when both are pending.
module cache_mem_responder #(
   parameter int MEM_WORDS = 1024,
   parameter int RD_LAT    = 2
) (
   input logic                  clk,
   input logic                  rst,
   cache_mem_responder_if.slave bus
);
   localparam int         AW        = $clog2(MEM_WORDS);
   localparam logic [2:0] TYPE_LINE = 3'b100;
   localparam logic [3:0] LAT_LOAD  = 4'(RD_LAT - 1);

   typedef enum logic [1:0] {
      IDLE,
      WR_COMMIT,
      RD_WAIT,
      RD_BURST
   } state_e;

   state_e          state_q, state_d;
   logic [3:0]      latCnt_q, latCnt_d;
   logic [1:0]      beat_q, beat_d;
   logic [AW-1:0]   rdIdx_q, rdIdx_d;
   logic [AW-1:0]   wrIdx_q, wrIdx_d;
   logic            rdLine_q, rdLine_d;
   logic            wrLine_q, wrLine_d;
   logic [3:0]      wrStrb_q, wrStrb_d;
   logic [127:0]    wrData_q, wrData_d;

   logic [31:0]     mem [MEM_WORDS];
   logic            memWe;
   logic [AW-1:0]   beatIdx;
   logic [AW-1:0]   wrWordIdx;
   logic [31:0]     wrWord;
   logic [3:0]      wrBytes;
   logic            lastBeat;
   logic            unusedBits;

   // Line requests align to a 4-word boundary; beats then OR in their offset.
   function automatic logic [AW-1:0] wordIndex(input logic [AW-1:0] idx, input logic isLine);
      logic [AW-1:0] res;
      res = idx;
      if (isLine) res[1:0] = 2'b00;
      return res;
   endfunction

   assign beatIdx    = AW'(beat_q);
   assign wrWordIdx  = wrIdx_q | beatIdx;
   assign wrWord     = wrLine_q ? wrData_q[{beat_q, 5'd0} +: 32] : wrData_q[31:0];
   assign wrBytes    = wrLine_q ? 4'hF : wrStrb_q;
   assign lastBeat   = !rdLine_q || (beat_q == 2'd3);
   assign unusedBits = ^{bus.rd_addr[31:AW+2], bus.rd_addr[1:0],
                         bus.wr_addr[31:AW+2], bus.wr_addr[1:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         latCnt_q <= '0;
         beat_q   <= '0;
         rdIdx_q  <= '0;
         wrIdx_q  <= '0;
         rdLine_q <= 1'b0;
         wrLine_q <= 1'b0;
         wrStrb_q <= '0;
         wrData_q <= '0;
      end else begin
         state_q  <= state_d;
         latCnt_q <= latCnt_d;
         beat_q   <= beat_d;
         rdIdx_q  <= rdIdx_d;
         wrIdx_q  <= wrIdx_d;
         rdLine_q <= rdLine_d;
         wrLine_q <= wrLine_d;
         wrStrb_q <= wrStrb_d;
         wrData_q <= wrData_d;
      end
   end

   // Storage is deliberately left out of reset so a partially committed line survives it.
   always_ff @(posedge clk) begin
      if (memWe) begin
         for (int b = 0; b < 4; b++) begin
            if (wrBytes[b]) mem[wrWordIdx][8*b +: 8] <= wrWord[8*b +: 8];
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      latCnt_d      = latCnt_q;
      beat_d        = beat_q;
      rdIdx_d       = rdIdx_q;
      wrIdx_d       = wrIdx_q;
      rdLine_d      = rdLine_q;
      wrLine_d      = wrLine_q;
      wrStrb_d      = wrStrb_q;
      wrData_d      = wrData_q;
      memWe         = 1'b0;
      bus.rd_rdy    = 1'b0;
      bus.wr_rdy    = 1'b0;
      bus.ret_valid = 1'b0;
      bus.ret_last  = 1'b0;
      bus.ret_data  = '0;

      unique case (state_q)
         IDLE: begin
            bus.wr_rdy = 1'b1;
            bus.rd_rdy = !bus.wr_req;
            beat_d     = '0;
            if (bus.wr_req) begin
               wrLine_d = (bus.wr_type == TYPE_LINE);
               wrIdx_d  = wordIndex(bus.wr_addr[AW+1:2], bus.wr_type == TYPE_LINE);
               wrStrb_d = bus.wr_wstrb;
               wrData_d = bus.wr_data;
               state_d  = WR_COMMIT;
            end else if (bus.rd_req) begin
               rdLine_d = (bus.rd_type == TYPE_LINE);
               rdIdx_d  = wordIndex(bus.rd_addr[AW+1:2], bus.rd_type == TYPE_LINE);
               latCnt_d = LAT_LOAD;
               // A single-cycle latency has no wait phase at all.
               state_d  = (RD_LAT == 1) ? RD_BURST : RD_WAIT;
            end
         end
         WR_COMMIT: begin
            memWe  = 1'b1;
            beat_d = beat_q + 2'd1;
            if (!wrLine_q || beat_q == 2'd3) begin
               beat_d  = '0;
               state_d = IDLE;
            end
         end
         RD_WAIT: begin
            latCnt_d = latCnt_q - 4'd1;
            if (latCnt_q <= 4'd1) state_d = RD_BURST;
         end
         RD_BURST: begin
            bus.ret_valid = 1'b1;
            bus.ret_last  = lastBeat;
            bus.ret_data  = mem[rdIdx_q | beatIdx];
            beat_d        = beat_q + 2'd1;
            if (lastBeat) begin
               beat_d  = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Reset silences the bus in the very cycle it is raised, not one edge later.
      if (rst) begin
         memWe         = 1'b0;
         bus.rd_rdy    = 1'b0;
         bus.wr_rdy    = 1'b0;
         bus.ret_valid = 1'b0;
         bus.ret_last  = 1'b0;
         bus.ret_data  = '0;
      end
   end
endmodule

// File: tb/tb_cache_mem_responder.sv
// Drives three responders (read latency 2, 1 and 15) with identical requests and checks each
// return stream and handshake against a word-array memory model.
module tb_cache_mem_responder;
   localparam int         MEM_WORDS = 1024;
   localparam int         NUM_DUTS  = 3;
   localparam logic [2:0] TYPE_LINE = 3'b100;
   localparam logic [2:0] TYPE_WORD = 3'b010;

   logic         clk = 1'b0;
   logic         rst;
   logic         rdReq;
   logic [2:0]   rdType;
   logic [31:0]  rdAddr;
   logic         wrReq;
   logic [2:0]   wrType;
   logic [31:0]  wrAddr;
   logic [3:0]   wrStrb;
   logic [127:0] wrData;

   int           checks = 0;
   int           errors = 0;
   logic [31:0]  refMem [MEM_WORDS];

   always #5 clk = ~clk;

   cache_mem_responder_if busA ();
   cache_mem_responder_if busB ();
   cache_mem_responder_if busC ();

   assign busA.rd_req = rdReq;  assign busB.rd_req = rdReq;  assign busC.rd_req = rdReq;
   assign busA.rd_type = rdType; assign busB.rd_type = rdType; assign busC.rd_type = rdType;
   assign busA.rd_addr = rdAddr; assign busB.rd_addr = rdAddr; assign busC.rd_addr = rdAddr;
   assign busA.wr_req = wrReq;  assign busB.wr_req = wrReq;  assign busC.wr_req = wrReq;
   assign busA.wr_type = wrType; assign busB.wr_type = wrType; assign busC.wr_type = wrType;
   assign busA.wr_addr = wrAddr; assign busB.wr_addr = wrAddr; assign busC.wr_addr = wrAddr;
   assign busA.wr_wstrb = wrStrb; assign busB.wr_wstrb = wrStrb; assign busC.wr_wstrb = wrStrb;
   assign busA.wr_data = wrData; assign busB.wr_data = wrData; assign busC.wr_data = wrData;

   cache_mem_responder #(.MEM_WORDS(MEM_WORDS), .RD_LAT(2))  dutA (.clk(clk), .rst(rst), .bus(busA));
   cache_mem_responder #(.MEM_WORDS(MEM_WORDS), .RD_LAT(1))  dutB (.clk(clk), .rst(rst), .bus(busB));
   cache_mem_responder #(.MEM_WORDS(MEM_WORDS), .RD_LAT(15)) dutC (.clk(clk), .rst(rst), .bus(busC));

   logic [NUM_DUTS-1:0] obsValid, obsLast, obsRdRdy, obsWrRdy;
   logic [31:0]         obsData [NUM_DUTS];

   assign obsValid = {busC.ret_valid, busB.ret_valid, busA.ret_valid};
   assign obsLast  = {busC.ret_last,  busB.ret_last,  busA.ret_last};
   assign obsRdRdy = {busC.rd_rdy,    busB.rd_rdy,    busA.rd_rdy};
   assign obsWrRdy = {busC.wr_rdy,    busB.wr_rdy,    busA.wr_rdy};
   assign obsData[0] = busA.ret_data;
   assign obsData[1] = busB.ret_data;
   assign obsData[2] = busC.ret_data;

   function automatic int latOf(input int d);
      case (d)
         0:       return 2;
         1:       return 1;
         default: return 15;
      endcase
   endfunction

   function automatic int wordIdx(input logic [31:0] addr);
      return int'((addr >> 2) % MEM_WORDS);
   endfunction

   function automatic void modelWrite(input logic [31:0] addr, input logic [2:0] t,
                                      input logic [3:0] strb, input logic [127:0] data);
      int idx;
      idx = wordIdx(addr);
      if (t == TYPE_LINE) begin
         for (int k = 0; k < 4; k++) refMem[idx - idx % 4 + k] = data[32*k +: 32];
      end else begin
         for (int b = 0; b < 4; b++) if (strb[b]) refMem[idx][8*b +: 8] = data[8*b +: 8];
      end
   endfunction

   function automatic void modelRead(input logic [31:0] addr, input logic [2:0] t,
                                     output logic [31:0] w [4], output int n);
      int idx;
      idx = wordIdx(addr);
      for (int k = 0; k < 4; k++) w[k] = 32'h0;
      if (t == TYPE_LINE) begin
         n = 4;
         for (int k = 0; k < 4; k++) w[k] = refMem[idx - idx % 4 + k];
      end else begin
         n = 1;
         w[0] = refMem[idx];
      end
   endfunction

   function automatic logic [31:0] randAddr();
      logic [31:0] r;
      r = $urandom();
      return {r[31:12], 4'b0000, r[7:0]};
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic checkAll(input string tag, input logic expRdy, input logic expRdRdy);
      for (int d = 0; d < NUM_DUTS; d++) begin
         checkOutput($sformatf("%s dut%0d wr_rdy", tag, d), 32'(obsWrRdy[d]), 32'(expRdy));
         checkOutput($sformatf("%s dut%0d rd_rdy", tag, d), 32'(obsRdRdy[d]), 32'(expRdRdy));
         checkOutput($sformatf("%s dut%0d ret_valid", tag, d), 32'(obsValid[d]), 32'h0);
         checkOutput($sformatf("%s dut%0d ret_last", tag, d), 32'(obsLast[d]), 32'h0);
         checkOutput($sformatf("%s dut%0d ret_data", tag, d), obsData[d], 32'h0);
      end
   endtask

   // Cycle k is k edges after acceptance; a pulse of reset at rstCycle cancels everything pending.
   task automatic readWindow(input logic [31:0] w [4], input int n, input int rstCycle);
      for (int k = 1; k <= 21; k++) begin
         rst = (k == rstCycle);
         #1;
         for (int d = 0; d < NUM_DUTS; d++) begin
            int          beat;
            logic        expValid, expLast, expRdy;
            logic [31:0] expData;
            beat     = k - latOf(d);
            expValid = (beat >= 0) && (beat < n) && (rstCycle == 0 || k < rstCycle);
            expLast  = expValid && (beat == n - 1);
            expData  = 32'h0;
            if (expValid) expData = w[beat];
            if (rstCycle != 0 && k >= rstCycle) expRdy = (k > rstCycle);
            else expRdy = (k >= latOf(d) + n);
            checkOutput($sformatf("rd c%0d dut%0d ret_valid", k, d), 32'(obsValid[d]), 32'(expValid));
            checkOutput($sformatf("rd c%0d dut%0d ret_last", k, d), 32'(obsLast[d]), 32'(expLast));
            checkOutput($sformatf("rd c%0d dut%0d ret_data", k, d), obsData[d], expData);
            checkOutput($sformatf("rd c%0d dut%0d rd_rdy", k, d), 32'(obsRdRdy[d]), 32'(expRdy));
            checkOutput($sformatf("rd c%0d dut%0d wr_rdy", k, d), 32'(obsWrRdy[d]), 32'(expRdy));
         end
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulusRead(input logic [31:0] addr, input logic [2:0] t, input int rstCycle);
      logic [31:0] w [4];
      int          n;
      rdReq  = 1'b1;
      rdAddr = addr;
      rdType = t;
      #1;
      for (int d = 0; d < NUM_DUTS; d++)
         checkOutput($sformatf("rd accept dut%0d rd_rdy", d), 32'(obsRdRdy[d]), 32'h1);
      modelRead(addr, t, w, n);
      @(posedge clk);
      #1;
      rdReq = 1'b0;
      readWindow(w, n, rstCycle);
   endtask

   task automatic applyStimulusWrite(input logic [31:0] addr, input logic [2:0] t,
                                     input logic [3:0] strb, input logic [127:0] data,
                                     input logic withRead, input logic [2:0] readType);
      logic [31:0] w [4];
      int          n, nr;
      wrReq  = 1'b1;
      wrAddr = addr;
      wrType = t;
      wrStrb = strb;
      wrData = data;
      rdReq  = withRead;
      rdAddr = addr;
      rdType = readType;
      #1;
      for (int d = 0; d < NUM_DUTS; d++) begin
         checkOutput($sformatf("wr accept dut%0d wr_rdy", d), 32'(obsWrRdy[d]), 32'h1);
         checkOutput($sformatf("wr accept dut%0d rd_rdy", d), 32'(obsRdRdy[d]), 32'h0);
      end
      @(posedge clk);
      #1;
      wrReq = 1'b0;
      modelWrite(addr, t, strb, data);
      n = (t == TYPE_LINE) ? 4 : 1;
      for (int k = 1; k <= n; k++) begin
         checkAll($sformatf("wr commit c%0d", k), 1'b0, 1'b0);
         @(posedge clk);
         #1;
      end
      checkAll("wr done", 1'b1, 1'b1);
      if (withRead) begin
         modelRead(addr, readType, w, nr);
         @(posedge clk);
         #1;
         rdReq = 1'b0;
         readWindow(w, nr, 0);
      end
   endtask

   // Reset lands in the third commit cycle, after words 0 and 1 have been stored.
   task automatic applyStimulusAbortWrite(input logic [31:0] addr, input logic [127:0] data);
      int idx;
      wrReq  = 1'b1;
      wrAddr = addr;
      wrType = TYPE_LINE;
      wrStrb = 4'($urandom());
      wrData = data;
      @(posedge clk);
      #1;
      wrReq = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst = 1'b1;
      #1;
      checkAll("wr abort in reset", 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      checkAll("wr abort after reset", 1'b1, 1'b1);
      idx = wordIdx(addr);
      refMem[idx - idx % 4]     = data[31:0];
      refMem[idx - idx % 4 + 1] = data[63:32];
   endtask

   initial begin
      #300000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] r;
      int          sel;
      logic [31:0] addr;

      rst    = 1'b1;
      rdReq  = 1'b0;
      rdType = '0;
      rdAddr = '0;
      wrReq  = 1'b0;
      wrType = '0;
      wrAddr = '0;
      wrStrb = '0;
      wrData = '0;
      for (int i = 0; i < MEM_WORDS; i++) refMem[i] = 32'h0;

      $display("[TB] reset");
      repeat (2) @(posedge clk);
      #1;
      checkAll("in reset", 1'b0, 1'b0);
      rst = 1'b0;
      #1;
      checkAll("after reset", 1'b1, 1'b1);

      $display("[TB] fill lines 0..15");
      for (int l = 0; l < 16; l++) begin
         r = $urandom();
         applyStimulusWrite({r[31:12], 4'b0000, 4'(l), r[3:0]}, TYPE_LINE, r[11:8], rand128(),
                            1'b0, TYPE_WORD);
      end

      $display("[TB] directed line / word / wrap");
      applyStimulusWrite(32'h0000_0100, TYPE_LINE, 4'h0,
                         128'h33333333_22222222_11111111_00000000, 1'b0, TYPE_WORD);
      applyStimulusRead(32'h0000_0104, TYPE_LINE, 0);
      applyStimulusWrite(32'h0000_0108, TYPE_WORD, 4'b0101,
                         {96'h0123_4567_89AB_CDEF_FEDC_BA98, 32'hAABBCCDD}, 1'b0, TYPE_WORD);
      applyStimulusRead(32'h0000_0108, TYPE_WORD, 0);
      checkOutput("model word 0x108", refMem[66], 32'h22BB22DD);
      applyStimulusRead(32'h0000_1100, TYPE_LINE, 0);
      applyStimulusWrite(32'h0000_0104, 3'b000, 4'b0000, rand128(), 1'b0, TYPE_WORD);
      applyStimulusRead(32'h0000_0104, 3'b001, 0);
      applyStimulusWrite(32'h0000_010C, 3'b111, 4'b1111, rand128(), 1'b1, TYPE_LINE);

      $display("[TB] reset mid-burst and mid-commit");
      applyStimulusRead(32'h0000_0100, TYPE_LINE, 4);
      applyStimulusRead(32'h0000_0104, TYPE_LINE, 0);
      applyStimulusAbortWrite(32'h0000_0020, rand128());
      applyStimulusRead(32'h0000_0020, TYPE_LINE, 0);

      $display("[TB] random traffic");
      for (int i = 0; i < 50; i++) begin
         sel  = $urandom_range(0, 9);
         addr = randAddr();
         if (sel < 5) begin
            applyStimulusRead(addr, 3'($urandom_range(0, 7)), 0);
         end else begin
            applyStimulusWrite(addr, 3'($urandom_range(0, 7)), 4'($urandom()), rand128(),
                               sel >= 8, 3'($urandom_range(0, 7)));
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
